timestamp_timer_mc: RTL and testbench
=====================================

Name: timestamp_timer_mc

Overview:
Multi-channel timestamp unit for the GALS producer/consumer path. One shared free-running counter of WIDTH bits advances at a programmable prescaled rate. Each of CH channels captures the counter value on request and holds it behind a valid/ready handshake until its consumer accepts it. Supports wrap or saturate mode, a sticky overflow flag and sticky per-channel drop flags.

Parameters:
WIDTH, 16, counter and timestamp width in bits (>=2)
CH, 2, number of capture channels (>=1)
PRESC_W, 8, width of prescaler divisor input

Ports:
reset  in  1  asynchronous, active-high; clears all state
clock_1  in  1  single clock; all logic rises on posedge clock_1
run  in  1  counter advances only while 1
clr  in  1  synchronous clear of counter, prescaler, t_ovf, t_drop
mode_sat  in  1  0 = wrap at max, 1 = saturate at max
presc_div  in  PRESC_W  tick every presc_div+1 enabled cycles
t_en  in  CH  per-channel capture request (bit i = channel i)
t_ready  in  CH  per-channel consumer accept
t_valid  out  CH  per-channel timestamp held and valid
t_out  out  CH*WIDTH  channel i timestamp at bits [i*WIDTH +: WIDTH]
t_ovf  out  1  sticky: counter reached max and a further tick occurred
t_drop  out  CH  sticky: request lost because channel was full

Behaviour:
- Reset (async, active-high): counter=0, prescaler=0, t_valid=0, t_out=0, t_ovf=0, t_drop=0. Assertion mid-handshake discards held data immediately.
- Prescaler: when run=1 and clr=0 each cycle: if presc_cnt==presc_div then tick=1 and presc_cnt<=0, else presc_cnt<=presc_cnt+1. presc_div=0 -> tick every cycle. run=0 freezes presc_cnt and counter. presc_div change mid-count: compare uses new value; if presc_cnt already exceeds it, count runs up to all-ones, wraps to 0 and continues (no early tick).
- Counter on tick: below all-ones -> +1. At all-ones: wrap mode -> 0 and t_ovf<=1; saturate mode -> hold all-ones and t_ovf<=1.
- clr: counter, presc_cnt, t_ovf and t_drop go to 0 next cycle; overrides tick in same cycle. Does not touch t_valid/t_out.
- Capture value: registered counter value in request cycle (pre-increment). Latency: t_en in cycle N -> t_valid=1 and t_out valid in cycle N+1.
- Per-channel handshake, evaluated each cycle:
  - t_valid=0, t_en=1: capture, t_valid<=1.
  - t_valid=1, t_ready=1, t_en=0: t_valid<=0; t_out holds last value.
  - t_valid=1, t_ready=1, t_en=1: accept old and capture new in same cycle; t_valid stays 1.
  - t_valid=1, t_ready=0, t_en=1: request dropped; t_out unchanged; t_drop[i]<=1.
  - t_out must not change while t_valid=1 and t_ready=0.
- Channels are independent; simultaneous requests on several channels capture the same value.
- t_ready ignored while t_valid=0.
- clr and t_en in same cycle: capture gets pre-clear counter value.

Decomposition:
- Package timestamp_pkg: MODE_WRAP=1'b0, MODE_SAT=1'b1 constants; default WIDTH/CH localparams.
- Sub-module ts_channel (one capture register + valid/ready/drop logic, WIDTH param), instantiated CH times via generate. Counter and prescaler stay in top.

Test Plan:
- Reset then run=1, presc_div=0, WIDTH=16: t_en[0] pulsed with counter=5 -> next cycle t_valid[0]=1, t_out[0]=5; hold t_ready=0 for 10 cycles -> t_out stable at 5; t_ready=1 -> t_valid[0]=0 next cycle.
- presc_div=3: counter increments exactly once per 4 cycles; run=0 for 6 cycles -> counter and prescaler frozen; resume continues phase.
- WIDTH=4, wrap mode: counter 15 + tick -> 0, t_ovf=1. Saturate mode: stays 15, t_ovf=1. clr -> counter=0, t_ovf=0.
- Channel 1 holding 7 with t_ready=0, new t_en[1] -> t_out[1] stays 7, t_drop[1]=1; t_drop[0] stays 0.
- Back-to-back: t_en[0]=1 and t_ready[0]=1 every cycle with presc_div=0 -> t_valid[0] continuously 1, t_out[0] increments by 1 per cycle, no drops.
- Async reset asserted mid-cycle with both channels valid -> t_valid=0, t_out=0, t_ovf=0 immediately, without waiting for a clock_1 edge.

Source files
------------

// File: rtl/timestamp_pkg.sv
// Shared constants for the multi-channel timestamp unit.
package timestamp_pkg;

   localparam logic MODE_WRAP   = 1'b0;
   localparam logic MODE_SAT    = 1'b1;

   localparam int   DEF_WIDTH   = 16;
   localparam int   DEF_CH      = 2;
   localparam int   DEF_PRESC_W = 8;

endpackage

// File: rtl/ts_channel.sv
// One capture register with valid/ready hold and sticky drop; capture visible one cycle after req.
// Holds its value while valid && !ready; a request arriving then is dropped and flagged.
module ts_channel
   import timestamp_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic             clock_1,
   input  logic             reset,
   input  logic             clr,
   input  logic [WIDTH-1:0] count,
   input  logic             req,
   input  logic             ready,
   output logic             valid,
   output logic [WIDTH-1:0] stamp,
   output logic             drop
);

   logic take;

   // A slot is free when empty or when its current value is accepted this cycle.
   assign take = req && (!valid || ready);

   always_ff @(posedge clock_1 or posedge reset) begin
      if (reset) begin
         valid <= 1'b0;
         stamp <= '0;
         drop  <= 1'b0;
      end else begin
         if (take) begin
            stamp <= count;
            valid <= 1'b1;
         end else if (valid && ready) begin
            valid <= 1'b0;
         end

         if (clr) begin
            drop <= 1'b0;
         end else if (req && valid && !ready) begin
            drop <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/timestamp_timer_mc.sv
// Shared prescaled free-running counter feeding CH independent capture channels; capture latency 1 cycle.
// Each channel holds its timestamp until accepted; requests to a full channel are dropped.
module timestamp_timer_mc
   import timestamp_pkg::*;
#(
   parameter int WIDTH   = DEF_WIDTH,
   parameter int CH      = DEF_CH,
   parameter int PRESC_W = DEF_PRESC_W
) (
   input  logic                  reset,
   input  logic                  clock_1,
   input  logic                  run,
   input  logic                  clr,
   input  logic                  mode_sat,
   input  logic [PRESC_W-1:0]    presc_div,
   input  logic [CH-1:0]         t_en,
   input  logic [CH-1:0]         t_ready,
   output logic [CH-1:0]         t_valid,
   output logic [CH*WIDTH-1:0]   t_out,
   output logic                  t_ovf,
   output logic [CH-1:0]         t_drop
);

   localparam logic [WIDTH-1:0]   CNT_MAX   = '1;
   localparam logic [WIDTH-1:0]   CNT_ONE   = {{(WIDTH-1){1'b0}}, 1'b1};
   localparam logic [PRESC_W-1:0] PRESC_ONE = {{(PRESC_W-1){1'b0}}, 1'b1};

   logic [PRESC_W-1:0] presc_cnt;
   logic [WIDTH-1:0]   count;
   logic               ovf;
   logic               tick;

   // Exact-match compare: if presc_div drops below presc_cnt the prescaler
   // runs through all-ones and wraps before the next tick.
   assign tick = run && (presc_cnt == presc_div);

   always_ff @(posedge clock_1 or posedge reset) begin
      if (reset) begin
         presc_cnt <= '0;
         count     <= '0;
         ovf       <= 1'b0;
      end else if (clr) begin
         presc_cnt <= '0;
         count     <= '0;
         ovf       <= 1'b0;
      end else if (run) begin
         if (tick) begin
            presc_cnt <= '0;
            if (count != CNT_MAX) begin
               count <= count + CNT_ONE;
            end else begin
               ovf <= 1'b1;
               if (mode_sat == MODE_WRAP) begin
                  count <= '0;
               end
            end
         end else begin
            presc_cnt <= presc_cnt + PRESC_ONE;
         end
      end
   end

   assign t_ovf = ovf;

   for (genvar i = 0; i < CH; i++) begin : g_ch
      ts_channel #(
         .WIDTH (WIDTH)
      ) u_ch (
         .clock_1 (clock_1),
         .reset   (reset),
         .clr     (clr),
         .count   (count),
         .req     (t_en[i]),
         .ready   (t_ready[i]),
         .valid   (t_valid[i]),
         .stamp   (t_out[i*WIDTH +: WIDTH]),
         .drop    (t_drop[i])
      );
   end

endmodule

// File: tb/tb_timestamp_timer_mc.sv
// Directed bench: a 16-bit and a 4-bit instance share all stimulus; the 4-bit one exercises wrap/saturate.
module tb_timestamp_timer_mc;

   logic        reset;
   logic        clock_1;
   logic        run;
   logic        clr;
   logic        mode_sat;
   logic [7:0]  presc_div;
   logic [1:0]  t_en;
   logic [1:0]  t_ready;

   logic [1:0]  t_valid16, t_drop16, t_valid4, t_drop4;
   logic [31:0] t_out16;
   logic [7:0]  t_out4;
   logic        t_ovf16, t_ovf4;

   int vectors = 0;
   int miscompares = 0;

   timestamp_timer_mc #(.WIDTH(16), .CH(2), .PRESC_W(8)) dut16 (
      .reset(reset), .clock_1(clock_1), .run(run), .clr(clr), .mode_sat(mode_sat),
      .presc_div(presc_div), .t_en(t_en), .t_ready(t_ready), .t_valid(t_valid16),
      .t_out(t_out16), .t_ovf(t_ovf16), .t_drop(t_drop16)
   );

   timestamp_timer_mc #(.WIDTH(4), .CH(2), .PRESC_W(8)) dut4 (
      .reset(reset), .clock_1(clock_1), .run(run), .clr(clr), .mode_sat(mode_sat),
      .presc_div(presc_div), .t_en(t_en), .t_ready(t_ready), .t_valid(t_valid4),
      .t_out(t_out4), .t_ovf(t_ovf4), .t_drop(t_drop4)
   );

   initial clock_1 = 1'b0;
   always #5 clock_1 = ~clock_1;

   task automatic cyc();
      @(posedge clock_1);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      reset = 1'b1; run = 1'b0; clr = 1'b0; mode_sat = 1'b0;
      presc_div = 8'd0; t_en = 2'b00; t_ready = 2'b00;
      repeat (2) cyc();
      chk("rst_valid", {30'd0, t_valid16}, 32'd0);
      chk("rst_out",   t_out16, 32'd0);
      chk("rst_ovf",   {31'd0, t_ovf16}, 32'd0);
      chk("rst_drop",  {30'd0, t_drop16}, 32'd0);

      // Basic capture of counter value 5 and hold under backpressure
      reset = 1'b0; run = 1'b1;
      repeat (5) cyc();
      t_en = 2'b01;
      cyc();
      chk("cap5_valid", {31'd0, t_valid16[0]}, 32'd1);
      chk("cap5_out16", {16'd0, t_out16[15:0]}, 32'd5);
      chk("cap5_out4",  {28'd0, t_out4[3:0]}, 32'd5);
      t_en = 2'b00;
      for (int k = 0; k < 10; k++) begin
         cyc();
         chk("hold_out",   {16'd0, t_out16[15:0]}, 32'd5);
         chk("hold_valid", {31'd0, t_valid16[0]}, 32'd1);
      end
      t_ready = 2'b01;
      cyc();
      chk("accept_valid", {31'd0, t_valid16[0]}, 32'd0);
      chk("accept_hold",  {16'd0, t_out16[15:0]}, 32'd5);

      // Prescaler divide-by-4, freeze with run=0, resume keeps phase
      clr = 1'b1; presc_div = 8'd3; t_en = 2'b00; t_ready = 2'b00;
      cyc();
      clr = 1'b0; t_en = 2'b01; t_ready = 2'b01;
      for (int k = 1; k <= 9; k++) begin
         cyc();
         chk("presc4", {16'd0, t_out16[15:0]}, (k - 1) / 4);
      end
      run = 1'b0;
      for (int k = 0; k < 6; k++) begin
         cyc();
         chk("frozen", {16'd0, t_out16[15:0]}, 32'd2);
      end
      run = 1'b1;
      cyc(); chk("resume_a", {16'd0, t_out16[15:0]}, 32'd2);
      cyc(); chk("resume_b", {16'd0, t_out16[15:0]}, 32'd2);
      cyc(); chk("resume_c", {16'd0, t_out16[15:0]}, 32'd2);
      cyc(); chk("resume_d", {16'd0, t_out16[15:0]}, 32'd3);

      // clr with capture in same cycle, then back-to-back captures
      clr = 1'b1; presc_div = 8'd0;
      cyc();
      chk("clr_precap", {16'd0, t_out16[15:0]}, 32'd3);
      clr = 1'b0;
      for (int k = 1; k <= 7; k++) begin
         cyc();
         chk("b2b_out",   {16'd0, t_out16[15:0]}, k - 1);
         chk("b2b_valid", {31'd0, t_valid16[0]}, 32'd1);
      end
      chk("b2b_nodrop", {30'd0, t_drop16}, 32'd0);

      // Channel 1 full with 7, further request is dropped
      t_en = 2'b11; t_ready = 2'b01;
      cyc();
      chk("ch1_cap7",   {16'd0, t_out16[31:16]}, 32'd7);
      chk("ch_both_v",  {30'd0, t_valid16}, 32'd3);
      t_en = 2'b10; t_ready = 2'b00;
      cyc();
      chk("drop_hold",  {16'd0, t_out16[31:16]}, 32'd7);
      chk("drop_flag",  {30'd0, t_drop16}, 32'd2);
      chk("drop_flag4", {30'd0, t_drop4}, 32'd2);
      chk("drop_out4",  {28'd0, t_out4[7:4]}, 32'd7);
      t_en = 2'b00; t_ready = 2'b11;
      cyc();
      chk("drain_valid", {30'd0, t_valid16}, 32'd0);
      chk("drain_hold",  {16'd0, t_out16[31:16]}, 32'd7);

      // Wrap mode on the 4-bit instance
      clr = 1'b1; mode_sat = 1'b0;
      cyc();
      chk("clr_drop", {30'd0, t_drop16}, 32'd0);
      chk("clr_ovf4", {31'd0, t_ovf4}, 32'd0);
      clr = 1'b0;
      repeat (15) cyc();
      t_en = 2'b01; t_ready = 2'b01;
      cyc();
      chk("wrap_cap15", {28'd0, t_out4[3:0]}, 32'd15);
      chk("wrap_cap16", {16'd0, t_out16[15:0]}, 32'd15);
      chk("wrap_ovf4",  {31'd0, t_ovf4}, 32'd1);
      chk("wrap_ovf16", {31'd0, t_ovf16}, 32'd0);
      cyc();
      chk("wrap_to0",   {28'd0, t_out4[3:0]}, 32'd0);
      chk("wide_16",    {16'd0, t_out16[15:0]}, 32'd16);

      // Asynchronous reset between clock edges with both channels valid
      t_en = 2'b11; t_ready = 2'b11;
      cyc();
      chk("pre_rst_valid", {30'd0, t_valid4}, 32'd3);
      chk("pre_rst_ovf",   {31'd0, t_ovf4}, 32'd1);
      #2 reset = 1'b1;
      #1;
      chk("arst_valid4", {30'd0, t_valid4}, 32'd0);
      chk("arst_out4",   {24'd0, t_out4}, 32'd0);
      chk("arst_ovf4",   {31'd0, t_ovf4}, 32'd0);
      chk("arst_valid16", {30'd0, t_valid16}, 32'd0);
      chk("arst_out16",  t_out16, 32'd0);
      t_en = 2'b00; t_ready = 2'b00;
      cyc();
      reset = 1'b0;

      // Saturate mode, then clr releases the overflow flag
      mode_sat = 1'b1;
      repeat (18) cyc();
      t_en = 2'b01; t_ready = 2'b01;
      cyc();
      chk("sat_cap15", {28'd0, t_out4[3:0]}, 32'd15);
      chk("sat_ovf4",  {31'd0, t_ovf4}, 32'd1);
      chk("sat_cap16", {16'd0, t_out16[15:0]}, 32'd18);
      clr = 1'b1;
      cyc();
      chk("sat_clr_cap", {28'd0, t_out4[3:0]}, 32'd15);
      chk("sat_clr_ovf", {31'd0, t_ovf4}, 32'd0);
      clr = 1'b0;
      cyc();
      chk("post_clr4",  {28'd0, t_out4[3:0]}, 32'd0);
      chk("post_clr16", {16'd0, t_out16[15:0]}, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
